riscv_apu_arbiter: RTL and testbench

- Shares one APU (FPU/DSP unit) between NB_CORES core-side APU dispatchers.
- Round-robin arbitration on the request channel. The grant is combinational in the same cycle, so each dispatcher's nack-stall behaviour is unchanged.
- An ID FIFO records the issuing core of every accepted operation. In-order APU responses are routed back to that core.
- Sits in the cluster between the per-core dispatchers and the shared APU.

---
 rtl/riscv_apu_arb_pkg.sv | 23 ++
 rtl/riscv_apu_arbiter_if.sv | 37 +++
 rtl/riscv_apu_id_fifo.sv | 50 +++++
 rtl/riscv_apu_arbiter.sv | 102 ++++++++++
 tb/tb_riscv_apu_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_apu_arb_pkg.sv
// Shared types and helpers for the cluster APU arbiter and the per-core dispatcher integration.
package riscv_apu_arb_pkg;

   localparam int unsigned REQ_W_DEF  = 128;
   localparam int unsigned RESP_W_DEF = 37;

   // Width of a core index; a single core still needs one bit.
   function automatic int unsigned id_width(input int unsigned nb_cores);
      return (nb_cores > 1) ? $clog2(nb_cores) : 1;
   endfunction

   typedef struct packed {
      logic [2:0][31:0] operands;
      logic [5:0]       op;
      logic [25:0]      flags;
   } apu_req_t;

   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  flags;
   } apu_resp_t;

endpackage

// File: rtl/riscv_apu_arbiter_if.sv
// Core-side and APU-side handshake bundle of the shared-APU arbiter.
interface riscv_apu_arbiter_if
   import riscv_apu_arb_pkg::*;
#(
   parameter int unsigned NB_CORES = 4,
   parameter int unsigned REQ_W    = REQ_W_DEF,
   parameter int unsigned RESP_W   = RESP_W_DEF
) ();

   logic [NB_CORES-1:0]            core_req_i;
   logic [NB_CORES-1:0][REQ_W-1:0] core_payload_i;
   logic [NB_CORES-1:0]            core_gnt_o;
   logic [NB_CORES-1:0]            core_rvalid_o;
   logic [RESP_W-1:0]              core_rdata_o;
   logic                           apu_req_o;
   logic [REQ_W-1:0]               apu_payload_o;
   logic                           apu_gnt_i;
   logic                           apu_rvalid_i;
   logic [RESP_W-1:0]              apu_rdata_i;
   logic                           busy_o;
   logic                           err_o;

   // Arbiter side
   modport slave (
      input  core_req_i, core_payload_i, apu_gnt_i, apu_rvalid_i, apu_rdata_i,
      output core_gnt_o, core_rvalid_o, core_rdata_o, apu_req_o, apu_payload_o,
             busy_o, err_o
   );

   // Cores plus APU, as seen from outside the arbiter
   modport master (
      output core_req_i, core_payload_i, apu_gnt_i, apu_rvalid_i, apu_rdata_i,
      input  core_gnt_o, core_rvalid_o, core_rdata_o, apu_req_o, apu_payload_o,
             busy_o, err_o
   );

endinterface

// File: rtl/riscv_apu_id_fifo.sv
// Issuing-core ID queue for in-order APU responses; head is read combinationally.
module riscv_apu_id_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic [W-1:0]                 wdata,
   output logic [W-1:0]                 head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wrap_inc(wr_ptr);
         if (pop)  rd_ptr <= wrap_inc(rd_ptr);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/riscv_apu_arbiter.sv
// Round-robin sharing of one APU between NB_CORES dispatchers, with in-order response routing.
module riscv_apu_arbiter
   import riscv_apu_arb_pkg::*;
#(
   parameter int unsigned NB_CORES = 4,
   parameter int unsigned REQ_W    = REQ_W_DEF,
   parameter int unsigned RESP_W   = RESP_W_DEF,
   parameter int unsigned DEPTH    = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   riscv_apu_arbiter_if.slave    bus
);

   localparam int unsigned ID_W  = id_width(NB_CORES);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     winner;
   logic [ID_W-1:0]     head;
   logic                found;
   logic                full;
   logic                empty;
   logic                apu_req;
   logic                accept;
   logic                bypass;
   logic                push;
   logic                pop;
   logic                err;
   logic [CNT_W-1:0]    count;
   logic [NB_CORES-1:0] gnt;
   logic [NB_CORES-1:0] rvalid;
   logic [REQ_W-1:0]    payload;
   logic [RESP_W-1:0]   rdata;

   // First requester at or after rr_ptr, wrapping around.
   always_comb begin
      int unsigned idx;
      idx    = 0;
      found  = 1'b0;
      winner = '0;
      for (int unsigned i = 0; i < NB_CORES; i++) begin
         idx = 32'(rr_ptr) + i;
         if (idx >= NB_CORES) idx = idx - NB_CORES;
         if (!found && bus.core_req_i[ID_W'(idx)]) begin
            found  = 1'b1;
            winner = ID_W'(idx);
         end
      end
   end

   // Fullness uses the registered count only, so a same-cycle pop never frees a slot.
   assign apu_req = found && !full;
   assign accept  = apu_req && bus.apu_gnt_i;
   assign bypass  = accept && bus.apu_rvalid_i && empty;
   assign push    = accept && !bypass;
   assign pop     = bus.apu_rvalid_i && !empty;
   assign payload = apu_req ? bus.core_payload_i[winner] : '0;
   assign rdata   = bus.apu_rdata_i;

   always_comb begin
      gnt    = '0;
      rvalid = '0;
      if (accept) gnt[winner] = 1'b1;
      if (pop)         rvalid[head]   = 1'b1;
      else if (bypass) rvalid[winner] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr <= '0;
         err    <= 1'b0;
      end else begin
         if (accept) rr_ptr <= (32'(winner) == NB_CORES - 1) ? '0 : winner + ID_W'(1);
         if (bus.apu_rvalid_i && empty && !accept) err <= 1'b1;
      end
   end

   riscv_apu_id_fifo #(
      .DEPTH (DEPTH),
      .W     (ID_W)
   ) u_id_fifo (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .push  (push),
      .pop   (pop),
      .wdata (winner),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign bus.core_gnt_o    = gnt;
   assign bus.core_rvalid_o = rvalid;
   assign bus.core_rdata_o  = rdata;
   assign bus.apu_req_o     = apu_req;
   assign bus.apu_payload_o = payload;
   assign bus.busy_o        = (count != '0);
   assign bus.err_o         = err;

endmodule

// File: tb/tb_riscv_apu_arbiter.sv
// Self-checking bench for riscv_apu_arbiter: directed scenarios plus a randomized run against a queue model.
module tb_riscv_apu_arbiter;
   import riscv_apu_arb_pkg::*;

   localparam int unsigned NB    = 4;
   localparam int unsigned RW    = REQ_W_DEF;
   localparam int unsigned SW    = RESP_W_DEF;
   localparam int unsigned DEPTH = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   riscv_apu_arbiter_if #(.NB_CORES(NB), .REQ_W(RW), .RESP_W(SW)) bus ();

   riscv_apu_arbiter #(.NB_CORES(NB), .REQ_W(RW), .RESP_W(SW), .DEPTH(DEPTH)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int passed = 0;
   int total  = 0;

   // Reference model: round-robin pointer, queue of issuing cores, sticky error.
   int unsigned m_rr;
   int unsigned m_ids[$];
   bit          m_err;

   logic [NB-1:0] e_gnt;
   logic [NB-1:0] e_rvalid;
   logic          e_req;
   logic [RW-1:0] e_payload;
   int unsigned   e_win;
   bit            e_acc;
   bit            e_byp;

   function automatic void model_eval();
      bit any;
      any   = 1'b0;
      e_win = 0;
      for (int unsigned k = 0; k < NB; k++) begin
         int unsigned c;
         c = (m_rr + k) % NB;
         if (!any && bus.core_req_i[c]) begin
            any   = 1'b1;
            e_win = c;
         end
      end
      e_req     = any && (m_ids.size() < DEPTH);
      e_payload = e_req ? bus.core_payload_i[e_win] : '0;
      e_acc     = e_req && bus.apu_gnt_i;
      e_byp     = e_acc && bus.apu_rvalid_i && (m_ids.size() == 0);
      e_gnt     = e_acc ? (NB'(1) << e_win) : '0;
      e_rvalid  = '0;
      if (bus.apu_rvalid_i && m_ids.size() != 0) e_rvalid = NB'(1) << m_ids[0];
      else if (e_byp)                            e_rvalid = NB'(1) << e_win;
   endfunction

   function automatic void model_commit();
      if (bus.apu_rvalid_i) begin
         if (m_ids.size() != 0) m_ids.delete(0);
         else if (!e_acc)       m_err = 1'b1;
      end
      if (e_acc && !e_byp) m_ids.push_back(e_win);
      if (e_acc) m_rr = (e_win + 1) % NB;
   endfunction

   task automatic step();
      model_eval();
      model_commit();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n              = 1'b0;
      bus.core_req_i     = '0;
      bus.core_payload_i = '0;
      bus.apu_gnt_i      = 1'b0;
      bus.apu_rvalid_i   = 1'b0;
      bus.apu_rdata_i    = '0;
      m_rr  = 0;
      m_ids.delete();
      m_err = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic rand_payloads();
      for (int c = 0; c < NB; c++)
         bus.core_payload_i[c] = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      if (bus.core_gnt_o !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", bus.core_gnt_o); else passed++;
      total++;
      if (bus.core_rvalid_o !== 4'b0000) $display("FAIL reset_rvalid: got %b want 0000", bus.core_rvalid_o); else passed++;
      total++;
      if (bus.apu_req_o !== 1'b0) $display("FAIL reset_apu_req: got %b want 0", bus.apu_req_o); else passed++;
      total++;
      if (bus.apu_payload_o !== '0) $display("FAIL reset_payload: got %h want 0", bus.apu_payload_o); else passed++;
      total++;
      if (bus.busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy_o); else passed++;
      total++;
      if (bus.err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.err_o); else passed++;
      total++;
   endtask

   task automatic test_single_latency2();
      logic [RW-1:0] p1;
      logic [SW-1:0] rd;
      int            busy_cycles;
      do_reset();
      rand_payloads();
      p1 = bus.core_payload_i[1];
      bus.core_req_i = 4'b0010;
      bus.apu_gnt_i  = 1'b1;
      #1;
      if (bus.core_gnt_o !== 4'b0010) $display("FAIL lat2_gnt: got %b want 0010", bus.core_gnt_o); else passed++;
      total++;
      if (bus.apu_payload_o !== p1) $display("FAIL lat2_payload: got %h want %h", bus.apu_payload_o, p1); else passed++;
      total++;
      step();
      bus.core_req_i = '0;
      busy_cycles = 0;
      for (int k = 0; k < 3; k++) begin
         bus.apu_rvalid_i = (k == 1);
         rd = SW'({$urandom(), $urandom()});
         bus.apu_rdata_i = rd;
         #1;
         if (bus.busy_o === 1'b1) busy_cycles++;
         if (k == 1) begin
            if (bus.core_rvalid_o !== 4'b0010) $display("FAIL lat2_rvalid: got %b want 0010", bus.core_rvalid_o); else passed++;
            total++;
            if (bus.core_rdata_o !== rd) $display("FAIL lat2_rdata: got %h want %h", bus.core_rdata_o, rd); else passed++;
            total++;
         end else begin
            if (bus.core_rvalid_o !== 4'b0000) $display("FAIL lat2_no_rvalid: got %b want 0000", bus.core_rvalid_o); else passed++;
            total++;
         end
         step();
      end
      bus.apu_rvalid_i = 1'b0;
      if (busy_cycles != 2) $display("FAIL lat2_busy_len: got %0d want 2", busy_cycles); else passed++;
      total++;
   endtask

   task automatic test_fairness();
      logic [NB-1:0] want;
      logic [NB-1:0] prev;
      do_reset();
      rand_payloads();
      bus.core_req_i = 4'b0101;
      bus.apu_gnt_i  = 1'b1;
      prev = '0;
      for (int k = 0; k < 8; k++) begin
         want = (k % 2 == 0) ? 4'b0001 : 4'b0100;
         bus.apu_rvalid_i = (k > 0);
         #1;
         if (bus.core_gnt_o !== want) $display("FAIL fair_gnt[%0d]: got %b want %b", k, bus.core_gnt_o, want); else passed++;
         total++;
         if (k > 0) begin
            if (bus.core_rvalid_o !== prev) $display("FAIL fair_rvalid[%0d]: got %b want %b", k, bus.core_rvalid_o, prev); else passed++;
            total++;
         end
         prev = want;
         step();
      end
      bus.core_req_i   = '0;
      bus.apu_rvalid_i = 1'b1;
      #1;
      if (bus.core_rvalid_o !== prev) $display("FAIL fair_drain: got %b want %b", bus.core_rvalid_o, prev); else passed++;
      total++;
      step();
      bus.apu_rvalid_i = 1'b0;
      #1;
      if (bus.busy_o !== 1'b0) $display("FAIL fair_idle_busy: got %b want 0", bus.busy_o); else passed++;
      total++;
   endtask

   task automatic test_full();
      logic [NB-1:0] want;
      do_reset();
      rand_payloads();
      bus.core_req_i = 4'b1111;
      bus.apu_gnt_i  = 1'b1;
      for (int c = 0; c < 4; c++) begin
         want = NB'(1) << c;
         #1;
         if (bus.core_gnt_o !== want) $display("FAIL full_fill_gnt[%0d]: got %b want %b", c, bus.core_gnt_o, want); else passed++;
         total++;
         step();
         bus.core_req_i[c] = 1'b0;
      end
      bus.core_req_i[0] = 1'b1;
      #1;
      if (bus.apu_req_o !== 1'b0) $display("FAIL full_apu_req: got %b want 0", bus.apu_req_o); else passed++;
      total++;
      if (bus.core_gnt_o !== 4'b0000) $display("FAIL full_gnt: got %b want 0000", bus.core_gnt_o); else passed++;
      total++;
      step();
      bus.apu_rvalid_i = 1'b1;
      #1;
      if (bus.core_rvalid_o !== 4'b0001) $display("FAIL full_pop_rvalid: got %b want 0001", bus.core_rvalid_o); else passed++;
      total++;
      if (bus.core_gnt_o !== 4'b0000) $display("FAIL full_pop_gnt: got %b want 0000", bus.core_gnt_o); else passed++;
      total++;
      step();
      bus.apu_rvalid_i = 1'b0;
      #1;
      if (bus.core_gnt_o !== 4'b0001) $display("FAIL full_fifth_gnt: got %b want 0001", bus.core_gnt_o); else passed++;
      total++;
      step();
      bus.core_req_i   = '0;
      bus.apu_rvalid_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         want = NB'(1) << ((k + 1) % NB);
         #1;
         if (bus.core_rvalid_o !== want) $display("FAIL full_drain[%0d]: got %b want %b", k, bus.core_rvalid_o, want); else passed++;
         total++;
         step();
      end
      bus.apu_rvalid_i = 1'b0;
   endtask

   task automatic test_bypass();
      do_reset();
      rand_payloads();
      bus.core_req_i   = 4'b1000;
      bus.apu_gnt_i    = 1'b1;
      bus.apu_rvalid_i = 1'b1;
      #1;
      if (bus.core_rvalid_o !== 4'b1000) $display("FAIL byp_rvalid: got %b want 1000", bus.core_rvalid_o); else passed++;
      total++;
      if (bus.core_gnt_o !== 4'b1000) $display("FAIL byp_gnt: got %b want 1000", bus.core_gnt_o); else passed++;
      total++;
      step();
      bus.core_req_i   = '0;
      bus.apu_rvalid_i = 1'b0;
      #1;
      if (bus.busy_o !== 1'b0) $display("FAIL byp_busy: got %b want 0", bus.busy_o); else passed++;
      total++;
      if (bus.err_o !== 1'b0) $display("FAIL byp_err: got %b want 0", bus.err_o); else passed++;
      total++;
   endtask

   task automatic test_nack_hold();
      do_reset();
      rand_payloads();
      bus.core_req_i = 4'b0100;
      bus.apu_gnt_i  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         if (bus.apu_req_o !== 1'b1) $display("FAIL nack_req[%0d]: got %b want 1", k, bus.apu_req_o); else passed++;
         total++;
         if (bus.core_gnt_o !== 4'b0000) $display("FAIL nack_gnt[%0d]: got %b want 0000", k, bus.core_gnt_o); else passed++;
         total++;
         step();
      end
      bus.apu_gnt_i = 1'b1;
      #1;
      if (bus.core_gnt_o !== 4'b0100) $display("FAIL nack_final_gnt: got %b want 0100", bus.core_gnt_o); else passed++;
      total++;
      step();
      // Pointer should now sit at core 3, ahead of core 0.
      bus.core_req_i = 4'b1001;
      #1;
      if (bus.core_gnt_o !== 4'b1000) $display("FAIL nack_rr_next: got %b want 1000", bus.core_gnt_o); else passed++;
      total++;
      step();
      bus.core_req_i = '0;
   endtask

   task automatic test_error_reset();
      do_reset();
      bus.apu_rvalid_i = 1'b1;
      #1;
      if (bus.core_rvalid_o !== 4'b0000) $display("FAIL err_no_rvalid: got %b want 0000", bus.core_rvalid_o); else passed++;
      total++;
      step();
      bus.apu_rvalid_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         if (bus.err_o !== 1'b1) $display("FAIL err_sticky[%0d]: got %b want 1", k, bus.err_o); else passed++;
         total++;
         step();
      end
      rand_payloads();
      bus.apu_gnt_i  = 1'b1;
      bus.core_req_i = 4'b0011;
      step();
      step();
      bus.core_req_i = '0;
      #1;
      if (bus.busy_o !== 1'b1) $display("FAIL err_two_outstanding: got %b want 1", bus.busy_o); else passed++;
      total++;
      #2 rst_n = 1'b0;
      m_rr  = 0;
      m_ids.delete();
      m_err = 1'b0;
      #1;
      if (bus.busy_o !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", bus.busy_o); else passed++;
      total++;
      if (bus.err_o !== 1'b0) $display("FAIL rst_mid_err: got %b want 0", bus.err_o); else passed++;
      total++;
      @(negedge clk);
      rst_n = 1'b1;
      bus.apu_rvalid_i = 1'b1;
      step();
      bus.apu_rvalid_i = 1'b0;
      #1;
      if (bus.err_o !== 1'b1) $display("FAIL rst_late_resp_err: got %b want 1", bus.err_o); else passed++;
      total++;
      step();
   endtask

   task automatic test_random();
      logic [NB-1:0] pend;
      logic [SW-1:0] rd;
      logic          e_busy;
      do_reset();
      pend = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int c = 0; c < NB; c++) begin
            if (!pend[c] && $urandom_range(0, 2) == 0) begin
               pend[c] = 1'b1;
               bus.core_payload_i[c] = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
         end
         bus.core_req_i   = pend;
         bus.apu_gnt_i    = ($urandom_range(0, 3) != 0);
         bus.apu_rvalid_i = (m_ids.size() != 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
         rd = SW'({$urandom(), $urandom()});
         bus.apu_rdata_i = rd;
         #1;
         model_eval();
         e_busy = (m_ids.size() != 0);
         if (bus.core_gnt_o !== e_gnt) $display("FAIL rnd_gnt@%0d: got %b want %b", cyc, bus.core_gnt_o, e_gnt); else passed++;
         total++;
         if (bus.core_rvalid_o !== e_rvalid) $display("FAIL rnd_rvalid@%0d: got %b want %b", cyc, bus.core_rvalid_o, e_rvalid); else passed++;
         total++;
         if (bus.apu_req_o !== e_req) $display("FAIL rnd_apu_req@%0d: got %b want %b", cyc, bus.apu_req_o, e_req); else passed++;
         total++;
         if (bus.apu_payload_o !== e_payload) $display("FAIL rnd_payload@%0d: got %h want %h", cyc, bus.apu_payload_o, e_payload); else passed++;
         total++;
         if (bus.core_rdata_o !== rd) $display("FAIL rnd_rdata@%0d: got %h want %h", cyc, bus.core_rdata_o, rd); else passed++;
         total++;
         if (bus.busy_o !== e_busy) $display("FAIL rnd_busy@%0d: got %b want %b", cyc, bus.busy_o, e_busy); else passed++;
         total++;
         if (bus.err_o !== m_err) $display("FAIL rnd_err@%0d: got %b want %b", cyc, bus.err_o, m_err); else passed++;
         total++;
         if (e_acc) pend[e_win] = 1'b0;
         step();
      end
   endtask

   initial begin
      test_reset();
      test_single_latency2();
      test_fairness();
      test_full();
      test_bypass();
      test_nack_hold();
      test_error_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
